// File: rtl/cdc_rx_pkg.sv
// Shared types and elaboration helpers for the multi-channel CDC receive block.
package cdc_rx_pkg;

  typedef enum logic {
    CDC_LEVEL  = 1'b0,
    CDC_TOGGLE = 1'b1
  } cdc_mode_e;

  // Channel index width; a single channel still needs a 1-bit tag.
  function automatic int unsigned chan_idx_w(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/cdc_rx_fifo.sv
// Per-channel first-word-fall-through FIFO; pointer MSB distinguishes full from empty.
module cdc_rx_fifo
  import cdc_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int unsigned AW = $clog2(DEPTH) + 1;

  if (!is_pow2(DEPTH)) begin : gen_depth_check
    $error("cdc_rx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW-1] != rd_ptr_q[AW-1]) &&
                     (wr_ptr_q[AW-2:0] == rd_ptr_q[AW-2:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-2:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-2:0]] <= wr_data_i;
  end

endmodule

// File: rtl/cdc_rx_capture.sv
// Multi-channel CDC receiver: flag synchronisers, edge capture into per-channel FIFOs,
// round-robin merge into a single tagged valid/ready stream with sticky overflow flags.
module cdc_rx_capture
  import cdc_rx_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TOGGLE_MODE = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNELS*WIDTH-1:0]        in_data,
  input  logic [CHANNELS-1:0]              in_new,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [chan_idx_w(CHANNELS)-1:0]  out_chan,
  output logic [CHANNELS-1:0]              ovf,
  input  logic [CHANNELS-1:0]              ovf_clr
);

  localparam int unsigned CW = chan_idx_w(CHANNELS);
  localparam cdc_mode_e   Mode = (TOGGLE_MODE != 0) ? CDC_TOGGLE : CDC_LEVEL;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] hist_q;
  logic [CHANNELS-1:0] sync_last, capture;
  logic [CHANNELS-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0]    fifo_rd [CHANNELS];

  logic                grant_found, load;
  logic [CW-1:0]       grant_idx, ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [CW-1:0]       out_chan_q, out_chan_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= in_new;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign capture   = (Mode == CDC_TOGGLE) ? (sync_last ^ hist_q) : (sync_last & ~hist_q);

  for (genvar c = 0; c < CHANNELS; c++) begin : gen_chan
    // A full FIFO still accepts a word when it is being popped the same cycle.
    assign fifo_push[c] = capture[c] & (~fifo_full[c] | fifo_pop[c]);
    assign drop[c]      = capture[c] & fifo_full[c] & ~fifo_pop[c];
    assign fifo_pop[c]  = load & (grant_idx == CW'(c));

    cdc_rx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (fifo_push[c]),
      .pop_i     (fifo_pop[c]),
      .wr_data_i (in_data[c*WIDTH +: WIDTH]),
      .full_o    (fifo_full[c]),
      .empty_o   (fifo_empty[c]),
      .rd_data_o (fifo_rd[c])
    );
  end

  // Round-robin search: first non-empty channel at or after the pointer.
  always_comb begin
    int unsigned sum;
    logic [CW-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sum = 32'(ptr_q) + i;
      if (sum >= CHANNELS) sum = sum - CHANNELS;
      idx = CW'(sum);
      if (!grant_found && !fifo_empty[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign load = (!out_valid_q || out_ready) && grant_found;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_rd[grant_idx];
      out_chan_d  = grant_idx;
      ptr_d       = (32'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + CW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Set wins over a same-cycle clear.
  assign ovf_d = (ovf_q & ~ovf_clr) | drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ovf_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign ovf       = ovf_q;

endmodule
